instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit_pkg.sv | 26 ++
 rtl/instr_fetch_unit_if.sv | 27 ++
 rtl/instr_fetch_unit_next_pc_sel.sv | 35 +++
 rtl/instr_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit and the control unit:
// fetch FSM state encoding, the canonical NOP word and the RV32I opcodes
// decoded by both blocks.
package instr_fetch_unit_pkg;

    // Fetch FSM states. HALT is entered on a misaligned redirect and is
    // only left through rst_n.
    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_VALID = 2'b01,
        ST_HALT  = 2'b10
    } fetch_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Major opcodes shared by fetch and control
    localparam logic [6:0] OPC_LW     = 7'b000_0011;
    localparam logic [6:0] OPC_SW     = 7'b010_0011;
    localparam logic [6:0] OPC_R_TYPE = 7'b011_0011;
    localparam logic [6:0] OPC_I_TYPE = 7'b001_0011;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;
    localparam logic [6:0] OPC_BEQ    = 7'b110_0011;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus.
//   imem_req   : fetch request (fetch unit -> memory)
//   imem_addr  : word-aligned fetch address (fetch unit -> memory)
//   imem_ack   : response valid, rdata sampled in the same cycle (memory -> fetch unit)
//   imem_rdata : fetched instruction word (memory -> fetch unit)
interface instr_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/instr_fetch_unit_next_pc_sel.sv
// Combinational next-pc selection for the fetch unit.
//   pc, pc_plus4      : current instruction address and its sequential successor
//   pc_sel, jalr_sel  : redirect / register-indirect redirect selects
//   imm_ext           : sign-extended immediate for pc-relative targets
//   alu_result        : jalr target before bit-0 clear
//   target            : selected next pc
//   misalign          : target is not word-aligned (bit 1 set)
module next_pc_sel
    import instr_fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] pc_plus4,
    input  logic        pc_sel,
    input  logic        jalr_sel,
    input  logic [31:0] imm_ext,
    input  logic [31:0] alu_result,
    output logic [31:0] target,
    output logic        misalign
);

    // Target mux; all additions wrap modulo 2^32. jalr clears bit 0 as in RV32I.
    always_comb begin
        target   = pc_plus4;
        misalign = 1'b0;
        if (!pc_sel) begin
            target = pc_plus4;
        end else if (jalr_sel) begin
            target = alu_result & 32'hFFFF_FFFE;
        end else begin
            target = pc + imm_ext;
        end
        misalign = target[1];
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one instruction-memory request per
// instruction, holds the fetched word until the datapath retires it, and
// computes the next pc on retire. A misaligned redirect halts fetch until reset.
//   clk, rst_n     : clock, asynchronous active-low reset
//   imem           : instruction-memory bus (master side)
//   instr, pc      : held instruction and its address
//   pc_plus4       : pc + 4 (link value)
//   instr_valid    : instr/pc valid and stable
//   instr_ready    : datapath retires instr this cycle
//   pc_sel, jalr_sel, imm_ext, alu_result : redirect controls, sampled on retire
//   misalign_err   : sticky misaligned-redirect flag
//   retire_count   : retired instruction counter (wraps)
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    instr_fetch_unit_if.master        imem,
    output logic [31:0]               instr,
    output logic [31:0]               pc,
    output logic [31:0]               pc_plus4,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    input  logic                      pc_sel,
    input  logic                      jalr_sel,
    input  logic [31:0]               imm_ext,
    input  logic [31:0]               alu_result,
    output logic                      misalign_err,
    output logic [31:0]               retire_count
);

    fetch_state_e state_r;
    fetch_state_e state_next_s;

    logic [31:0] pc_r;
    logic [31:0] pc_plus4_r;
    logic [31:0] instr_r;
    logic        misalign_err_r;
    logic [31:0] retire_count_r;

    logic        imem_req_s;
    logic        instr_valid_s;
    logic        load_instr_s;
    logic        retire_s;
    logic [31:0] target_s;
    logic        target_misalign_s;

    next_pc_sel u_next_pc_sel (
        .pc         (pc_r),
        .pc_plus4   (pc_plus4_r),
        .pc_sel     (pc_sel),
        .jalr_sel   (jalr_sel),
        .imm_ext    (imm_ext),
        .alu_result (alu_result),
        .target     (target_s),
        .misalign   (target_misalign_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state and state-decoded controls; ack only counts in FETCH
    always_comb begin
        state_next_s  = state_r;
        imem_req_s    = 1'b0;
        instr_valid_s = 1'b0;
        load_instr_s  = 1'b0;
        retire_s      = 1'b0;
        case (state_r)
            ST_FETCH: begin
                imem_req_s = 1'b1;
                if (imem.imem_ack) begin
                    load_instr_s = 1'b1;
                    state_next_s = ST_VALID;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_VALID: begin
                instr_valid_s = 1'b1;
                if (instr_ready) begin
                    retire_s = 1'b1;
                    if (target_misalign_s) begin
                        state_next_s = ST_HALT;
                    end else begin
                        state_next_s = ST_FETCH;
                    end
                end else begin
                    state_next_s = ST_VALID;
                end
            end
            ST_HALT: begin
                state_next_s = ST_HALT;
            end
            default: begin
                // Unreachable encoding: stop fetching rather than guess a pc
                state_next_s = ST_HALT;
            end
        endcase
    end

    // Instruction, pc and status registers; a faulting redirect keeps the
    // faulting pc but still counts the retire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r           <= RESET_PC;
            pc_plus4_r     <= RESET_PC + 32'd4;
            instr_r        <= NOP_INSTR;
            misalign_err_r <= 1'b0;
            retire_count_r <= 32'd0;
        end else begin
            if (load_instr_s) begin
                instr_r <= imem.imem_rdata;
            end
            if (retire_s) begin
                retire_count_r <= retire_count_r + 32'd1;
                if (target_misalign_s) begin
                    misalign_err_r <= 1'b1;
                end else begin
                    pc_r       <= target_s;
                    pc_plus4_r <= target_s + 32'd4;
                end
            end
        end
    end

    assign imem.imem_req  = imem_req_s;
    assign imem.imem_addr = pc_r;
    assign instr          = instr_r;
    assign pc             = pc_r;
    assign pc_plus4       = pc_plus4_r;
    assign instr_valid    = instr_valid_s;
    assign misalign_err   = misalign_err_r;
    assign retire_count   = retire_count_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, table-driven bench for instr_fetch_unit with hand-written
// sequences for halt-on-misalign and reset aborts.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        instr_ready;
    logic        pc_sel;
    logic        jalr_sel;
    logic [31:0] imm_ext;
    logic [31:0] alu_result;
    logic        misalign_err;
    logic [31:0] retire_count;

    instr_fetch_unit_if imem_bus ();

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem         (imem_bus),
        .instr        (instr),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .pc_sel       (pc_sel),
        .jalr_sel     (jalr_sel),
        .imm_ext      (imm_ext),
        .alu_result   (alu_result),
        .misalign_err (misalign_err),
        .retire_count (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        pc_sel;
        logic        jalr_sel;
        logic [31:0] imm;
        logic [31:0] alu;
        logic [31:0] exp_pc;
        logic [31:0] exp_next;
        int          n_wait;
        int          n_stall;
    } vec_t;

    vec_t        vecs [8];
    int          n_cmp;
    int          n_bad;
    logic [31:0] exp_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'hBAD0_BAD0;
        instr_ready         = 1'b0;
        pc_sel              = 1'b1;
        jalr_sel            = 1'b1;
        imm_ext             = 32'h0000_0002;
        alu_result          = 32'h0000_0007;
    endtask

    // Called at a negedge with the DUT in FETCH at v.exp_pc
    task automatic run_instr(input vec_t v);
        check("fetch_req", imem_bus.imem_req, 32'd1);
        check("fetch_addr", imem_bus.imem_addr, v.exp_pc);
        check("fetch_valid", instr_valid, 32'd0);
        for (int w = 0; w < v.n_wait; w++) begin
            imem_bus.imem_ack = 1'b0;
            @(negedge clk);
            check("wait_addr", imem_bus.imem_addr, v.exp_pc);
            check("wait_valid", instr_valid, 32'd0);
        end
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = v.rdata;
        @(negedge clk);
        drive_idle();
        check("valid", instr_valid, 32'd1);
        check("instr", instr, v.rdata);
        check("pc", pc, v.exp_pc);
        check("pc_plus4", pc_plus4, v.exp_pc + 32'd4);
        check("valid_req", imem_bus.imem_req, 32'd0);
        for (int s = 0; s < v.n_stall; s++) begin
            // Ack and redirect controls outside retire must be ignored
            imem_bus.imem_ack   = 1'b1;
            imem_bus.imem_rdata = 32'hDEAD_0000 + s;
            @(negedge clk);
            check("stall_instr", instr, v.rdata);
            check("stall_pc", pc, v.exp_pc);
            check("stall_valid", instr_valid, 32'd1);
            check("stall_cnt", retire_count, exp_cnt);
        end
        imem_bus.imem_ack = 1'b0;
        instr_ready       = 1'b1;
        pc_sel            = v.pc_sel;
        jalr_sel          = v.jalr_sel;
        imm_ext           = v.imm;
        alu_result        = v.alu;
        @(negedge clk);
        drive_idle();
        exp_cnt = exp_cnt + 32'd1;
        check("retire_cnt", retire_count, exp_cnt);
        check("next_req", imem_bus.imem_req, 32'd1);
        check("next_addr", imem_bus.imem_addr, v.exp_next);
        check("next_valid", instr_valid, 32'd0);
        check("no_misalign", misalign_err, 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req"}, imem_bus.imem_req, 32'd1);
        check({tag, "_addr"}, imem_bus.imem_addr, 32'h0000_0000);
        check({tag, "_instr"}, instr, 32'h0000_0013);
        check({tag, "_valid"}, instr_valid, 32'd0);
        check({tag, "_cnt"}, retire_count, 32'd0);
        check({tag, "_mis"}, misalign_err, 32'd0);
        check({tag, "_p4"}, pc_plus4, 32'h0000_0004);
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        exp_cnt = 32'd0;
        rst_n   = 1'b0;
        drive_idle();

        //          rdata          sel   jalr  imm            alu            pc             next           wt st
        vecs[0] = '{32'h0050_0093, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 0, 0};
        vecs[1] = '{32'h00C0_006F, 1'b1, 1'b0, 32'h0000_000C, 32'h0000_0000, 32'h0000_0004, 32'h0000_0010, 0, 0};
        vecs[2] = '{32'hFE00_0CE3, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_0010, 32'h0000_0008, 5, 3};
        vecs[3] = '{32'h0000_8067, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0201, 32'h0000_0008, 32'h0000_0200, 0, 0};
        vecs[4] = '{32'h0000_8067, 1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFD, 32'h0000_0200, 32'hFFFF_FFFC, 0, 0};
        vecs[5] = '{32'h0000_0013, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 0, 2};
        vecs[6] = '{32'h0020_8133, 1'b0, 1'b1, 32'h0000_0006, 32'h0000_0003, 32'h0000_0000, 32'h0000_0004, 1, 0};
        vecs[7] = '{32'hFFDF_F06F, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0000, 0, 0};

        // Reset state, with an ack during reset that must be ignored
        @(negedge clk);
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'h1234_5678;
        @(negedge clk);
        check_reset_state("rst");
        imem_bus.imem_ack = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_instr(vecs[i]);
        end

        // Misaligned jalr target 0x102: halt, keep pc, count the retire
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'h0000_8067;
        @(negedge clk);
        drive_idle();
        check("mis_valid", instr_valid, 32'd1);
        instr_ready = 1'b1;
        pc_sel      = 1'b1;
        jalr_sel    = 1'b1;
        alu_result  = 32'h0000_0103;
        @(negedge clk);
        exp_cnt = exp_cnt + 32'd1;
        check("mis_err", misalign_err, 32'd1);
        check("mis_req", imem_bus.imem_req, 32'd0);
        check("mis_valid0", instr_valid, 32'd0);
        check("mis_pc", pc, 32'h0000_0000);
        check("mis_cnt", retire_count, exp_cnt);
        imem_bus.imem_ack = 1'b1;
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            check("halt_req", imem_bus.imem_req, 32'd0);
            check("halt_valid", instr_valid, 32'd0);
            check("halt_err", misalign_err, 32'd1);
            check("halt_cnt", retire_count, exp_cnt);
        end
        drive_idle();
        rst_n = 1'b0;
        #1;
        check_reset_state("halt_rst");
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 32'd0;
        run_instr(vecs[0]);

        // Reset asserted mid-FETCH with ack high: abort immediately
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        rst_n               = 1'b0;
        #1;
        check_reset_state("fetch_rst");
        @(negedge clk);
        check("fetch_rst_instr2", instr, 32'h0000_0013);
        check("fetch_rst_pc2", pc, 32'h0000_0000);
        imem_bus.imem_ack = 1'b0;
        rst_n             = 1'b1;
        exp_cnt           = 32'd0;
        run_instr(vecs[0]);

        // Reset asserted mid-VALID
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'h0010_0113;
        @(negedge clk);
        drive_idle();
        check("vrst_pre", instr_valid, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_state("valid_rst");
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 32'd0;
        run_instr(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
